// File: rtl/fifo_rd_stream_24.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream_24
//
// Reader end of the 2048x24 synchronous pixel FIFO in the image_filter path.
// It drains the FIFO read port into a valid/ready pixel stream. The FIFO has
// no output register, so read data appears one cycle after fifo_rd_en. A
// 3-entry skid buffer absorbs that latency. Full throughput is kept, and there
// is no combinational path from m_ready to fifo_rd_en. Raster counters tag
// each beat with start-of-frame, end-of-line and end-of-frame markers.
//
// Ports
//   clk            system clock, shared with the FIFO
//   rst            synchronous active-high reset, shared with the FIFO
//   fifo_rd_en     read strobe to the FIFO
//   fifo_rd_data   FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_empty  FIFO empty flag
//   m_valid        stream data valid
//   m_ready        downstream ready
//   m_data         pixel data (head of the skid buffer)
//   m_sof          current beat is pixel (0,0) of the frame
//   m_eol          current beat is the last pixel of its line
//   m_eof          current beat is the last pixel of the frame
// -----------------------------------------------------------------------------
module fifo_rd_stream_24 #(
   parameter int DATA_WIDTH = 24,
   parameter int H_ACTIVE   = 1280,
   parameter int V_ACTIVE   = 720,
   parameter int CNT_W      = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   input  logic                  fifo_rd_empty,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_sof,
   output logic                  m_eol,
   output logic                  m_eof
);

   localparam logic [CNT_W-1:0] X_LAST = CNT_W'(H_ACTIVE - 1);
   localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(V_ACTIVE - 1);

   logic [1:0]            occ;       // words held in the skid buffer (0..3)
   logic                  infl;      // a FIFO read is in flight this cycle
   logic [1:0]            head;
   logic [1:0]            tail;
   logic [DATA_WIDTH-1:0] skid_q [3];
   logic [CNT_W-1:0]      x;
   logic [CNT_W-1:0]      y;

   logic [2:0]            pending;
   logic                  transfer;
   logic                  x_last;
   logic                  y_last;

   // Circular pointer over the 3 buffer slots: 0 -> 1 -> 2 -> 0.
   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   // Issue depends only on registered occupancy and the FIFO flag. Counting
   // the in-flight word means the buffer always has a free slot for any word
   // that lands. That is why occ can never exceed 3.
   assign pending    = {1'b0, occ} + {2'b0, infl};
   assign fifo_rd_en = !rst && !fifo_rd_empty && (pending <= 3'd2);

   assign m_valid  = !rst && (occ != 2'd0);
   assign transfer = m_valid && m_ready;
   assign m_data   = m_valid ? skid_q[head] : '0;

   assign x_last = (x == X_LAST);
   assign y_last = (y == Y_LAST);
   assign m_sof  = m_valid && (x == '0) && (y == '0);
   assign m_eol  = m_valid && x_last;
   assign m_eof  = m_valid && x_last && y_last;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         occ  <= 2'd0;
         infl <= 1'b0;
         head <= 2'd0;
         tail <= 2'd0;
         x    <= '0;
         y    <= '0;
      end else begin
         infl <= fifo_rd_en;
         if (infl) begin
            tail <= ptr_inc(tail);
         end
         if (transfer) begin
            head <= ptr_inc(head);
         end
         // Capture and transfer in the same cycle cancel out.
         occ <= occ + {1'b0, infl} - {1'b0, transfer};

         if (transfer) begin
            if (x_last) begin
               x <= '0;
               y <= y_last ? '0 : y + CNT_W'(1);
            end else begin
               x <= x + CNT_W'(1);
            end
         end
      end
   end

   // NOTE: the data slots have no reset. occ gates every read of them, so a
   // stale value is never presented as valid, and skipping the reset keeps
   // the reset fan-out off the datapath.
   always_ff @(posedge clk) begin
      if (infl) begin
         skid_q[tail] <= fifo_rd_data;
      end
   end

endmodule

// File: tb/tb_fifo_rd_stream_24.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_stream_24
//
// Directed bench for fifo_rd_stream_24 with H_ACTIVE=4 and V_ACTIVE=2. A small
// behavioural FIFO without an output register feeds the DUT. Each cycle the
// bench drives inputs at posedge+1 and samples outputs at posedge+2.
// -----------------------------------------------------------------------------
module tb_fifo_rd_stream_24;

   localparam int DW = 24;

   logic          clk;
   logic          rst;
   logic          fifo_rd_en;
   logic [DW-1:0] fifo_rd_data;
   logic          fifo_rd_empty;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;
   logic          m_sof;
   logic          m_eol;
   logic          m_eof;

   int checks = 0;
   int errors = 0;

   // Behavioural source FIFO.
   logic [DW-1:0] mem [2048];
   int            wr_cnt = 0;
   int            rd_cnt = 0;
   logic          hold_empty;

   // Expected raster position of the next accepted pixel.
   int mx = 0;
   int my = 0;

   fifo_rd_stream_24 #(
      .DATA_WIDTH (DW),
      .H_ACTIVE   (4),
      .V_ACTIVE   (2),
      .CNT_W      (12)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .fifo_rd_en    (fifo_rd_en),
      .fifo_rd_data  (fifo_rd_data),
      .fifo_rd_empty (fifo_rd_empty),
      .m_valid       (m_valid),
      .m_ready       (m_ready),
      .m_data        (m_data),
      .m_sof         (m_sof),
      .m_eol         (m_eol),
      .m_eof         (m_eof)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign fifo_rd_empty = (wr_cnt == rd_cnt) || hold_empty;

   always @(posedge clk) begin
      if (fifo_rd_en) begin
         fifo_rd_data <= mem[rd_cnt % 2048];
         rd_cnt       <= rd_cnt + 1;
      end
   end

   task automatic push(input logic [DW-1:0] v);
      mem[wr_cnt % 2048] = v;
      wr_cnt++;
   endtask

   task automatic advance_model();
      mx++;
      if (mx == 4) begin
         mx = 0;
         my = (my + 1) % 2;
      end
   endtask

   // -------------------------------------------------------------------------
   task automatic test_reset();
      // Hold reset for 2 cycles while the FIFO is empty.
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #1;
         #1;
         checks++;
         if ({fifo_rd_en, m_valid, m_sof, m_eol, m_eof, m_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs c=%0d got en=%b v=%b sof=%b eol=%b eof=%b data=%h expected all 0",
                     c, fifo_rd_en, m_valid, m_sof, m_eol, m_eof, m_data);
         end
      end
      @(posedge clk); #1;
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (c > 0) begin @(posedge clk); #1; end
         #1;
         checks++;
         if ({fifo_rd_en, m_valid} !== 2'b00) begin
            errors++;
            $display("FAIL idle_after_reset c=%0d got en=%b v=%b expected 0 0",
                     c, fifo_rd_en, m_valid);
         end
      end
   endtask

   // -------------------------------------------------------------------------
   task automatic test_full_rate();
      logic       exp_rd;
      logic       exp_v;
      logic [2:0] exp_mk;
      int         k;
      bit         found;
      @(posedge clk); #1;
      m_ready = 1'b1;
      for (int i = 1; i <= 8; i++) push(DW'(i));
      for (int c = 0; c < 12; c++) begin
         if (c > 0) begin @(posedge clk); #1; end
         #1;
         exp_rd = (c < 8);
         exp_v  = (c >= 2) && (c < 10);
         checks++;
         if (fifo_rd_en !== exp_rd || m_valid !== exp_v) begin
            errors++;
            $display("FAIL full_rate_handshake c=%0d got en=%b v=%b expected en=%b v=%b",
                     c, fifo_rd_en, m_valid, exp_rd, exp_v);
         end
         if (exp_v) begin
            k      = c - 1;
            exp_mk = {k == 1, k == 4 || k == 8, k == 8};
            checks++;
            if (m_data !== DW'(k) || {m_sof, m_eol, m_eof} !== exp_mk) begin
               errors++;
               $display("FAIL full_rate_pixel c=%0d got data=%h mk=%b expected data=%h mk=%b",
                        c, m_data, {m_sof, m_eol, m_eof}, DW'(k), exp_mk);
            end
         end
      end
      // Pixel 9 opens the second frame.
      @(posedge clk); #1;
      push(DW'(9));
      found = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin
         if (c > 0) begin @(posedge clk); #1; end
         #1;
         if (m_valid === 1'b1) found = 1'b1;
      end
      checks++;
      if (!found || m_data !== DW'(9) || {m_sof, m_eol, m_eof} !== 3'b100) begin
         errors++;
         $display("FAIL next_frame_sof got found=%b data=%h mk=%b expected found=1 data=000009 mk=100",
                  found, m_data, {m_sof, m_eol, m_eof});
      end
      mx = 1;
      my = 0;
   endtask

   // -------------------------------------------------------------------------
   task automatic test_backpressure();
      int         pulses;
      logic [2:0] exp_mk;
      pulses = 0;
      @(posedge clk); #1;
      m_ready = 1'b0;
      for (int i = 0; i < 10; i++) push(DW'(32'h100 + i));
      for (int c = 0; c < 8; c++) begin
         if (c > 0) begin @(posedge clk); #1; end
         #1;
         if (fifo_rd_en === 1'b1) pulses++;
         if (c >= 2) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== 24'h000100) begin
               errors++;
               $display("FAIL bp_hold c=%0d got v=%b data=%h expected v=1 data=000100",
                        c, m_valid, m_data);
            end
         end
      end
      checks++;
      if (pulses != 3) begin
         errors++;
         $display("FAIL bp_read_pulses got %0d expected 3", pulses);
      end
      @(posedge clk); #1;
      m_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (i > 0) begin @(posedge clk); #1; end
         #1;
         exp_mk = {mx == 0 && my == 0, mx == 3, mx == 3 && my == 1};
         checks++;
         if (m_valid !== 1'b1 || m_data !== DW'(32'h100 + i) ||
             {m_sof, m_eol, m_eof} !== exp_mk) begin
            errors++;
            $display("FAIL bp_drain i=%0d got v=%b data=%h mk=%b expected v=1 data=%h mk=%b",
                     i, m_valid, m_data, {m_sof, m_eol, m_eof}, DW'(32'h100 + i), exp_mk);
         end
         advance_model();
      end
      @(posedge clk); #1;
      #1;
      checks++;
      if (m_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_drained got v=%b expected 0", m_valid);
      end
   endtask

   // -------------------------------------------------------------------------
   task automatic test_random_stall();
      int            pushed;
      int            recv;
      logic          prev_valid;
      logic          prev_ready;
      logic [DW-1:0] prev_data;
      logic [2:0]    exp_mk;
      pushed     = 0;
      recv       = 0;
      prev_valid = 1'b0;
      prev_ready = 1'b0;
      prev_data  = '0;
      for (int cyc = 0; cyc < 20000 && recv < 1000; cyc++) begin
         @(posedge clk); #1;
         m_ready    = 1'($urandom_range(0, 1));
         hold_empty = ($urandom_range(0, 3) == 0);
         if (pushed < 1000 && $urandom_range(0, 1) == 1) begin
            push(DW'(32'h10000 + pushed));
            pushed++;
         end
         #1;
         checks++;
         if (fifo_rd_en === 1'b1 && fifo_rd_empty === 1'b1) begin
            errors++;
            $display("FAIL rnd_read_while_empty cyc=%0d got en=1 expected 0", cyc);
         end
         if (prev_valid && !prev_ready) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== prev_data) begin
               errors++;
               $display("FAIL rnd_stability cyc=%0d got v=%b data=%h expected v=1 data=%h",
                        cyc, m_valid, m_data, prev_data);
            end
         end
         if (m_valid === 1'b1 && m_ready === 1'b1) begin
            exp_mk = {mx == 0 && my == 0, mx == 3, mx == 3 && my == 1};
            checks++;
            if (m_data !== DW'(32'h10000 + recv) || {m_sof, m_eol, m_eof} !== exp_mk) begin
               errors++;
               $display("FAIL rnd_scoreboard n=%0d got data=%h mk=%b expected data=%h mk=%b",
                        recv, m_data, {m_sof, m_eol, m_eof}, DW'(32'h10000 + recv), exp_mk);
            end
            advance_model();
            recv++;
         end
         prev_valid = m_valid;
         prev_ready = m_ready;
         prev_data  = m_data;
      end
      checks++;
      if (recv != 1000) begin
         errors++;
         $display("FAIL rnd_word_count got %0d expected 1000", recv);
      end
      hold_empty = 1'b0;
   endtask

   // -------------------------------------------------------------------------
   task automatic test_reset_midstream();
      bit found;
      @(posedge clk); #1;
      m_ready = 1'b0;
      for (int i = 0; i < 5; i++) push(DW'(32'h200 + i));
      // Reads go out in cycles 0..2, so the buffer is full by cycle 4.
      for (int c = 1; c < 4; c++) @(posedge clk);
      @(posedge clk); #1;
      #1;
      checks++;
      if (m_valid !== 1'b1 || m_data !== 24'h000200) begin
         errors++;
         $display("FAIL mid_prefill got v=%b data=%h expected v=1 data=000200", m_valid, m_data);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      checks++;
      if ({fifo_rd_en, m_valid, m_sof, m_eol, m_eof, m_data} !== '0) begin
         errors++;
         $display("FAIL mid_reset_outputs got en=%b v=%b mk=%b data=%h expected all 0",
                  fifo_rd_en, m_valid, {m_sof, m_eol, m_eof}, m_data);
      end
      @(posedge clk); #1;
      rst     = 1'b0;
      m_ready = 1'b1;
      #1;
      checks++;
      if (m_valid !== 1'b0 || fifo_rd_en !== 1'b1) begin
         errors++;
         $display("FAIL mid_after_reset got v=%b en=%b expected v=0 en=1", m_valid, fifo_rd_en);
      end
      mx = 0;
      my = 0;
      found = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin
         @(posedge clk); #1;
         #1;
         if (m_valid === 1'b1) found = 1'b1;
      end
      checks++;
      if (!found || m_data !== 24'h000203 || m_sof !== 1'b1) begin
         errors++;
         $display("FAIL mid_first_pixel got found=%b data=%h sof=%b expected found=1 data=000203 sof=1",
                  found, m_data, m_sof);
      end
      @(posedge clk); #1;
      #1;
      checks++;
      if (m_valid !== 1'b1 || m_data !== 24'h000204 || m_sof !== 1'b0) begin
         errors++;
         $display("FAIL mid_second_pixel got v=%b data=%h sof=%b expected v=1 data=000204 sof=0",
                  m_valid, m_data, m_sof);
      end
   endtask

   // -------------------------------------------------------------------------
   task automatic test_empty_refill();
      int vcount;
      @(posedge clk); #1;
      rst     = 1'b1;
      m_ready = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      push(24'h000300);
      vcount = 0;
      for (int c = 0; c < 8; c++) begin
         if (c > 0) begin @(posedge clk); #1; end
         #1;
         if (m_valid === 1'b1) begin
            vcount++;
            checks++;
            if (m_data !== 24'h000300 || m_sof !== 1'b1) begin
               errors++;
               $display("FAIL refill_single_beat got data=%h sof=%b expected data=000300 sof=1",
                        m_data, m_sof);
            end
         end
      end
      checks++;
      if (vcount != 1) begin
         errors++;
         $display("FAIL refill_valid_cycles got %0d expected 1", vcount);
      end
      @(posedge clk); #1;
      push(24'h000301);
      #1;
      checks++;
      if (fifo_rd_en !== 1'b1) begin
         errors++;
         $display("FAIL refill_read_issue got en=%b expected 1", fifo_rd_en);
      end
      @(posedge clk); #1;
      #1;
      checks++;
      if (m_valid !== 1'b0) begin
         errors++;
         $display("FAIL refill_latency_n1 got v=%b expected 0", m_valid);
      end
      @(posedge clk); #1;
      #1;
      checks++;
      if (m_valid !== 1'b1 || m_data !== 24'h000301 || {m_sof, m_eol, m_eof} !== 3'b000) begin
         errors++;
         $display("FAIL refill_latency_n2 got v=%b data=%h mk=%b expected v=1 data=000301 mk=000",
                  m_valid, m_data, {m_sof, m_eol, m_eof});
      end
   endtask

   // -------------------------------------------------------------------------
   initial begin
      // NOTE: inputs are driven with blocking assignments at posedge+1.
      // That keeps them clear of the edge on which the DUT samples them.
      rst        = 1'b1;
      m_ready    = 1'b0;
      hold_empty = 1'b0;
      test_reset();
      test_full_rate();
      test_backpressure();
      test_random_stall();
      test_reset_midstream();
      test_empty_refill();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
